// File: rtl/rom_dl_scheduler.sv
// rom_dl_scheduler: steers the HPS ioctl download into 8 ROM regions with ack handshake, timeout and DIP/game capture.
// Define ROM_DL_CHECKSUM_EN to add a 16-bit wrapping sum of acknowledged bytes.
module rom_dl_scheduler #(
   parameter int REG_AW = 17,
   parameter int ACK_TO = 255
) (
   input  logic              i_clk,
   input  logic              RESETn,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [7:0]        rom_cs,
   output logic [REG_AW-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              rom_we,
   input  logic              rom_ack,
   output logic [15:0]       dsw,
   output logic [7:0]        game,
   output logic              dl_busy,
   output logic              dl_done,
   output logic [2:0]        err,
   output logic [15:0]       checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
   localparam logic [25:0] ADDR_LIM = 26'(8) << REG_AW;
   state_t state;
   logic dl_q;
   logic [7:0] to_cnt;
   logic rom_wr, in_range, ack_or_to;
   assign rom_wr = ioctl_wr && ioctl_index == 8'd0;
   assign in_range = {1'b0, ioctl_addr} < ADDR_LIM;
   assign ack_or_to = rom_ack || to_cnt == 8'(ACK_TO - 1);
`ifndef ROM_DL_CHECKSUM_EN
   assign checksum = 16'd0;
`endif
   // dl_q resets high so a download held across reset needs a fresh rising edge
   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
         dl_q <= 1'b1;
         to_cnt <= 8'd0;
         ioctl_wait <= 1'b0;
         rom_we <= 1'b0;
         rom_cs <= 8'd0;
         rom_addr <= '0;
         rom_data <= 8'd0;
         dsw <= 16'hFFFF;
         game <= 8'd0;
         dl_busy <= 1'b0;
         dl_done <= 1'b0;
         err <= 3'd0;
`ifdef ROM_DL_CHECKSUM_EN
         checksum <= 16'd0;
`endif
      end else begin
         dl_q <= ioctl_download;
         dl_done <= 1'b0;
         if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:1] == 24'd0) begin
            if (ioctl_addr[0]) dsw[15:8] <= ioctl_dout;
            else dsw[7:0] <= ioctl_dout;
         end
         if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) game <= ioctl_dout;
         case (state)
            IDLE: begin
               if (ioctl_download && !dl_q && ioctl_index == 8'd0) begin
                  state <= LOAD;
                  dl_busy <= 1'b1;
`ifdef ROM_DL_CHECKSUM_EN
                  checksum <= 16'd0;
`endif
               end
            end
            LOAD: begin
               if (!ioctl_download) begin
                  state <= DONE;
                  dl_busy <= 1'b0;
                  dl_done <= 1'b1;
               end else if (rom_wr && in_range) begin
                  state <= WRITE;
                  rom_we <= 1'b1;
                  ioctl_wait <= 1'b1;
                  rom_cs <= 8'd1 << ioctl_addr[REG_AW+2:REG_AW];
                  rom_addr <= ioctl_addr[REG_AW-1:0];
                  rom_data <= ioctl_dout;
                  to_cnt <= 8'd0;
               end else if (rom_wr) err[0] <= 1'b1;
            end
            WRITE: begin
               if (rom_wr) err[2] <= 1'b1;
               if (ack_or_to) begin
                  rom_we <= 1'b0;
                  rom_cs <= 8'd0;
                  ioctl_wait <= 1'b0;
                  to_cnt <= 8'd0;
                  if (!rom_ack) err[1] <= 1'b1;
`ifdef ROM_DL_CHECKSUM_EN
                  if (rom_ack) checksum <= checksum + {8'd0, rom_data};
`endif
                  state <= ioctl_download ? LOAD : DONE;
                  dl_busy <= ioctl_download;
                  dl_done <= !ioctl_download;
               end else to_cnt <= to_cnt + 8'd1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/rom_dl_scheduler.md
ROM_DL_SCHEDULER -- requirements
Module: rom_dl_scheduler

Interface
REQ-001 SHALL have parameter REG_AW, default 17: offset width of each of the 8 ROM regions, one region being 2^REG_AW bytes.
REQ-002 SHALL have parameter ACK_TO, default 255: maximum number of cycles to wait for rom_ack, range 1..255.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports ioctl_download (input, 1), ioctl_index (input, 8), ioctl_wr (input, 1), ioctl_addr (input, 25) and ioctl_dout (input, 8), which form the HPS download stream.
REQ-006 SHALL have port ioctl_wait, output, 1 bit: stalls the HPS stream.
REQ-007 SHALL have ports rom_cs (output, 8, one-hot region select), rom_addr (output, REG_AW), rom_data (output, 8) and rom_we (output, 1).
REQ-008 SHALL have port rom_ack, input, 1 bit: the target region accepted the write.
REQ-009 SHALL have port dsw, output, 16 bits: DIP bytes {sw1,sw0}.
REQ-010 SHALL have port game, output, 8 bits: game-select byte.
REQ-011 SHALL have ports dl_busy (output, 1), dl_done (output, 1, one-cycle pulse) and err (output, 3, sticky flags {proto,timeout,range}).
REQ-012 SHALL have port checksum, output, 16 bits.

Function
REQ-013 SHALL implement states IDLE, LOAD, WRITE and DONE.
REQ-014 SHALL, in IDLE, move to LOAD when ioctl_download=1 and ioctl_index=0, and SHALL clear checksum on that entry.
REQ-015 SHALL, in LOAD, on ioctl_wr=1 with ioctl_addr < 8*2^REG_AW, latch region = addr[REG_AW+2:REG_AW], offset = addr[REG_AW-1:0] and data, then enter WRITE on the next cycle.
REQ-016 SHALL, in LOAD, drop any write with ioctl_addr >= 8*2^REG_AW, set err[0], and stay in LOAD.
REQ-017 SHALL, in WRITE, hold rom_we=1, rom_cs one-hot and rom_addr/rom_data stable, and hold ioctl_wait=1, until rom_ack=1 is sampled.
REQ-018 SHALL, when rom_ack=1 is sampled in WRITE, deassert rom_we and ioctl_wait on the following cycle and return to LOAD.
REQ-019 SHALL count cycles spent in WRITE and, when the count reaches ACK_TO without rom_ack, drop the byte, set err[1] and return to LOAD.
REQ-020 SHALL ignore ioctl_wr=1 arriving during WRITE and set err[2].
REQ-021 SHALL, when ioctl_download falls in LOAD, move to DONE.
REQ-022 SHALL, when ioctl_download falls in WRITE, finish the pending write or timeout first, then move to DONE.
REQ-023 SHALL, in DONE, pulse dl_done for one cycle and return to IDLE.
REQ-024 SHALL drive dl_busy=1 in LOAD and WRITE.
REQ-025 SHALL, in any state, on ioctl_wr with index 254 and addr < 2, write byte sw[addr[0]] to dsw in the next cycle, without touching the FSM.
REQ-026 SHALL, in any state, on ioctl_wr with index 1 and addr = 0, load game in the next cycle.
REQ-027 SHALL drive rom_cs=0 and rom_we=0 whenever the state is not WRITE.
REQ-028 SHALL clear err only on reset.

Reset
REQ-029 SHALL, while RESETn=0, immediately force: state IDLE, ioctl_wait=0, rom_we=0, rom_cs=0, rom_addr=0, rom_data=0, dsw=16'hFFFF, game=0, dl_busy=0, dl_done=0, err=0, checksum=0, timeout counter=0.
REQ-030 SHALL, when reset occurs in WRITE, abandon the pending byte without issuing rom_we after release.
REQ-031 SHALL, after RESETn rises, stay in IDLE until a fresh rising edge of ioctl_download is seen with ioctl_index=0.

Configuration
REQ-032 SHALL, when macro ROM_DL_CHECKSUM_EN is defined, update checksum as a 16-bit wrapping sum of every byte acknowledged by rom_ack in the load, holding the value after DONE.
REQ-033 SHALL, when ROM_DL_CHECKSUM_EN is not defined, tie checksum to 0 and synthesize no adder.

Verification
REQ-034 SHALL cover this scenario: index 0, write addr 0x20005 data 0xA5, rom_ack after 3 cycles -> rom_cs=8'b0000_0010, rom_addr=5, ioctl_wait high for 4 cycles, checksum=0x00A5.
REQ-035 SHALL cover this scenario: write addr 0x100000 (REG_AW=17) -> no rom_we, err=3'b001, state stays LOAD.
REQ-036 SHALL cover this scenario: rom_ack held 0, ACK_TO=4 -> rom_we drops after 4 cycles, err[1]=1, next byte accepted normally.
REQ-037 SHALL cover this scenario: ioctl_download falls during WRITE, rom_ack 2 cycles later -> write completes, dl_done pulses exactly once, dl_busy=0.
REQ-038 SHALL cover this scenario: index 254 writes 0x3C at addr 0 and 0xC3 at addr 1 during a ROM load -> dsw=16'hC33C, ROM stream unaffected.
REQ-039 SHALL cover this scenario: RESETn pulsed low in WRITE -> all outputs at reset values in the same cycle, no rom_we after release, checksum=0.
